// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic-array weight-load path.
package tpu_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int PSUM_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, FILL, SHIFT, DONE} loader_state_t;

  // Flat index of PE(r,c) in an n x n array.
  function automatic int cap_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction
endpackage

// File: rtl/weight_buffer.sv
// N*N weight register file: sequential write stream, N combinational
// read ports (one per column, row selected by the caller).
module weight_buffer import tpu_pkg::*; #(
  parameter int N      = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        last,
  output logic                        full,
  input  logic [N-1:0][RW-1:0]        rd_row,
  output logic [N-1:0][DATA_W-1:0]    rd_data
);
  localparam int DEPTH = N * N;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wr_ptr;

  // The beat being written this cycle completes the matrix.
  assign last = wr_en && (wr_ptr == PW'(DEPTH - 1));

  // Write pointer, full flag and storage; clr rewinds for a new load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
      wr_ptr              <= wr_ptr + 1'b1;
      if (last) full <= 1'b1;
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_rd
    assign rd_data[c] = mem[AW'(int'(rd_row[c]) * N + c)];
  end
endmodule

// File: rtl/weight_loader.sv
// Loads an N x N weight matrix from a stream, then shifts it down the
// array's psum chains column-skewed so every PE captures its own weight.
module weight_loader import tpu_pkg::*; #(
  parameter int N      = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PSUM_W = PSUM_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_W-1:0]     w_data,
  output logic                  busy,
  output logic                  done,
  output logic                  en_weight_pass,
  output logic [N*N-1:0]        en_weight_capture,
  output logic [N*PSUM_W-1:0]   psum_top
);
  localparam int TW = $clog2(2 * N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  loader_state_t             state, next_state;
  logic [TW-1:0]             t;
  logic                      acc, last, full;
  logic [N-1:0][RW-1:0]      rd_row;
  logic [N-1:0][DATA_W-1:0]  rd_data;

  assign w_ready = (state == FILL) && !full;
  assign acc     = w_valid && w_ready;

  weight_buffer #(.N(N), .DATA_W(DATA_W), .RW(RW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     ((state == IDLE) && start),
    .wr_en   (acc),
    .wr_data (w_data),
    .last    (last),
    .full    (full),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // SHIFT cycle counter; held at zero outside SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              t <= '0;
    else if (state == SHIFT) t <= t + 1'b1;
    else                     t <= '0;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FILL;
      FILL:    if (last)  next_state = SHIFT;
      SHIFT:   if (t == TW'(2 * N - 2)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign en_weight_pass = (state == SHIFT);

  // Column c injects row N-1-k at cycle c+k; all its rows capture at c+N-1.
  for (genvar c = 0; c < N; c++) begin : g_col
    logic          live;
    logic [RW-1:0] row;

    // Select which buffered row (if any) column c presents this cycle.
    always_comb begin
      live = 1'b0;
      row  = '0;
      if (state == SHIFT && int'(t) >= c && int'(t) - c < N) begin
        live = 1'b1;
        row  = RW'(N - 1 - (int'(t) - c));
      end
    end

    assign rd_row[c] = row;
    assign psum_top[c*PSUM_W +: PSUM_W] =
      live ? {{(PSUM_W-DATA_W){1'b0}}, rd_data[c]} : '0;

    for (genvar r = 0; r < N; r++) begin : g_row
      assign en_weight_capture[cap_idx(r, c, N)] =
        (state == SHIFT) && (int'(t) == c + N - 1);
    end
  end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Drives the weight-load phase of the N×N weight-stationary systolic array from the top edge.
- Buffers one full N×N weight matrix from a valid/ready stream.
- Then injects each column's weights down that column's psum chain, bottom-row weight first, with columns skewed by one cycle.
- Raises en_weight_pass for the whole phase and per-PE en_weight_capture on the diagonal, so every PE latches its own weight.

Parameters:
- N, 2, array rows/columns.
- DATA_W, 8, weight width.
- PSUM_W, 16, psum chain width; weight occupies psum[DATA_W-1:0], upper bits zero.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  high only in FILL.
- w_data  in  DATA_W  weight W[r][c], row-major order (index r*N+c).
- busy  out  1  high in FILL, SHIFT, DONE.
- done  out  1  one-cycle pulse in DONE.
- en_weight_pass  out  1  high throughout SHIFT.
- en_weight_capture  out  N*N  bit r*N+c enables PE(r,c).
- psum_top  out  N*PSUM_W  slice c feeds in_psum of PE(0,c).

Behaviour:
- Reset (reset low, async):
  - state=IDLE; counters=0; buffer cleared to 0.
  - All outputs 0 immediately.
  - Reset mid-FILL/SHIFT aborts; no partial done.
- FSM states IDLE, FILL, SHIFT, DONE. Transitions:
  - IDLE -> FILL on start.
  - FILL -> SHIFT the cycle after beat N*N-1 is accepted.
  - SHIFT -> DONE after t=2N-2.
  - DONE -> IDLE unconditionally.
- FILL:
  - w_ready=1.
  - A beat is accepted when w_valid&&w_ready and written to buffer[wr_ptr]; wr_ptr increments.
  - Gaps in w_valid stall without error.
  - wr_ptr resets to 0 on entry.
- SHIFT, cycle counter t=0..2N-2:
  - psum_top[c] = {0, W[N-1-(t-c)][c]} when 0<=t-c<=N-1, else 0.
  - en_weight_capture[r*N+c] = (t == c+N-1), for all r.
  - en_weight_pass=1.
- Rationale: the PE psum chain is one register per row. A value injected at column c in cycle c+k reaches row N-1-k's in_psum in cycle c+N-1, so all rows of column c capture on the same edge.
- Outputs are decoded from registered state/counters only; there is no combinational path from inputs to outputs.
- DONE: done=1 for one cycle; en_weight_pass=0.
- Boundary cases:
  - start outside IDLE: ignored.
  - w_valid outside FILL: ignored.
  - start and w_valid in the same IDLE cycle: the beat is not accepted (w_ready=0).
  - Load duration: 2N-1 SHIFT cycles; a new start is accepted no earlier than the cycle after DONE.
- Width: weights are zero-extended into PSUM_W; no arithmetic.

Decomposition:
- tpu_pkg holds:
  - DATA_W/PSUM_W defaults.
  - loader_state_t enum {IDLE, FILL, SHIFT, DONE}.
  - helper function cap_idx(r,c)=r*N+c.
- Sub-module weight_buffer holds:
  - N*N×DATA_W register file.
  - Write pointer and full flag.
  - Async active-low clear.
  - Combinational read ports by (row,col).
- weight_loader keeps the FSM, SHIFT counter and output decode.

Test Plan:
- N=2, start, then weights 1,2,3,4 with continuous w_valid:
  - SHIFT t=0: psum_top={col1:0, col0:3}, capture=4'b0000.
  - t=1: {4,1}, capture=4'b0101.
  - t=2: {2,0}, capture=4'b1010.
  - done pulses the next cycle.
- Same weights with w_valid low every other cycle -> 8 FILL cycles; SHIFT sequence is identical to the previous case.
- Connect to a 2×2 array of PEs, load 1,2,3,4, then stream activations [1,1] -> column psums equal 4 and 6.
- Assert reset low during SHIFT t=1 -> all outputs 0 the same cycle, no done, state IDLE; a subsequent full load succeeds.
- start pulses during FILL and SHIFT -> ignored, wr_ptr not reset, exactly one done.
- w_valid high in IDLE with data 9, then start and 1,2,3,4 -> 9 never appears on psum_top.
